updown_sweep_ctrl: RTL and testbench

//   Sequencer for the W-bit up/down counter datapath. Loads the counter with a
//   low bound, then drives it lo->hi->lo ("one sweep") N times via step/direction

---
 rtl/updown_sweep_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_updown_sweep_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/updown_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// updown_sweep_ctrl
//
// Sequencer for an external W-bit up/down counter. On an accepted start it
// loads the counter with the low bound, then steps it lo->hi->lo ("one sweep")
// N times by watching the counter's q and driving step/direction. Supports
// pause (freeze), abort (return to idle without completion) and reports
// completion (done) and rejected starts (err).
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-high reset
//   start         request a sweep run; only looked at in IDLE
//   abort         cancel a running sweep (wins over pause)
//   pause         freeze counting and all state while high
//   lo_in, hi_in  sweep bounds, captured on an accepted start
//   n_in          number of sweeps, captured on an accepted start
//   cnt_q         current value of the external counter
//   cnt_load      counter load strobe (combinational)
//   cnt_load_val  counter load value (combinational)
//   cnt_en        counter step enable (combinational)
//   cnt_up        step direction, 1 = +1, 0 = -1 (combinational)
//   busy          registered; high in UP/DOWN/DONE
//   done          registered; one-cycle pulse at run completion
//   err           registered; one-cycle pulse after a rejected start
//   sweeps_done   registered; sweeps completed in the current run
// -----------------------------------------------------------------------------
module updown_sweep_ctrl #(
    parameter int W  = 4,
    parameter int NW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          pause,
    input  logic [W-1:0]  lo_in,
    input  logic [W-1:0]  hi_in,
    input  logic [NW-1:0] n_in,
    input  logic [W-1:0]  cnt_q,
    output logic          cnt_load,
    output logic [W-1:0]  cnt_load_val,
    output logic          cnt_en,
    output logic          cnt_up,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [NW-1:0] sweeps_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t        state_reg, state_next;
    logic [W-1:0]  lo_reg, lo_next;
    logic [W-1:0]  hi_reg, hi_next;
    logic [NW-1:0] n_reg, n_next;
    logic [NW-1:0] sweeps_reg, sweeps_next;
    logic          busy_reg, done_reg, err_reg;
    logic          err_next;

    logic          start_valid;
    logic [NW-1:0] sweeps_inc;

    assign start_valid = (lo_in < hi_in) && (n_in != '0);
    assign sweeps_inc  = sweeps_reg + NW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            lo_reg     <= '0;
            hi_reg     <= '0;
            n_reg      <= '0;
            sweeps_reg <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            lo_reg     <= lo_next;
            hi_reg     <= hi_next;
            n_reg      <= n_next;
            sweeps_reg <= sweeps_next;
            // Status flags are derived from the state being entered so they
            // line up with that state's cycle.
            busy_reg   <= (state_next != ST_IDLE);
            done_reg   <= (state_next == ST_DONE);
            err_reg    <= err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        lo_next      = lo_reg;
        hi_next      = hi_reg;
        n_next       = n_reg;
        sweeps_next  = sweeps_reg;
        err_next     = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_en       = 1'b0;
        cnt_up       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                cnt_load_val = lo_in;
                if (start) begin
                    if (start_valid) begin
                        cnt_load    = 1'b1;
                        lo_next     = lo_in;
                        hi_next     = hi_in;
                        n_next      = n_in;
                        sweeps_next = '0;
                        state_next  = ST_UP;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end

            ST_UP: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (!pause) begin
                    cnt_en = 1'b1;
                    // Turn at the top: the same cycle already steps down, so
                    // the counter never sits on hi for two cycles.
                    if (cnt_q == hi_reg) begin
                        cnt_up     = 1'b0;
                        state_next = ST_DOWN;
                    end else begin
                        cnt_up = 1'b1;
                    end
                end
            end

            ST_DOWN: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (!pause) begin
                    if (cnt_q != lo_reg) begin
                        cnt_en = 1'b1;
                        cnt_up = 1'b0;
                    end else begin
                        sweeps_next = sweeps_inc;
                        if (sweeps_inc == n_reg) begin
                            state_next = ST_DONE;
                        end else begin
                            cnt_en     = 1'b1;
                            cnt_up     = 1'b1;
                            state_next = ST_UP;
                        end
                    end
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // While reset is held the counter must see no activity at all.
        if (reset) begin
            cnt_load     = 1'b0;
            cnt_load_val = '0;
            cnt_en       = 1'b0;
            cnt_up       = 1'b0;
        end
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign err         = err_reg;
    assign sweeps_done = sweeps_reg;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
module tb_updown_sweep_ctrl;

    localparam int W  = 4;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic          pause;
    logic [W-1:0]  lo_in;
    logic [W-1:0]  hi_in;
    logic [NW-1:0] n_in;
    logic [W-1:0]  cnt_q = '0;
    logic          cnt_load;
    logic [W-1:0]  cnt_load_val;
    logic          cnt_en;
    logic          cnt_up;
    logic          busy;
    logic          done;
    logic          err;
    logic [NW-1:0] sweeps_done;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected counter values c1..c13 for lo=3, hi=6, n=2 (index 0 unused).
    int exp_q [0:13];

    always #5 clk = ~clk;

    // External counter: load has priority, otherwise step by +/-1.
    always @(posedge clk) begin
        if (cnt_load)
            cnt_q <= cnt_load_val;
        else if (cnt_en)
            cnt_q <= cnt_up ? cnt_q + 4'd1 : cnt_q - 4'd1;
    end

    updown_sweep_ctrl #(.W(W), .NW(NW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .pause        (pause),
        .lo_in        (lo_in),
        .hi_in        (hi_in),
        .n_in         (n_in),
        .cnt_q        (cnt_q),
        .cnt_load     (cnt_load),
        .cnt_load_val (cnt_load_val),
        .cnt_en       (cnt_en),
        .cnt_up       (cnt_up),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .sweeps_done  (sweeps_done)
    );

    // Inputs are driven 2 time units after the rising edge, outputs sampled 1 later.
    task automatic next_cyc;
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b1; abort = 1'b0; pause = 1'b0;
        lo_in = 4'd5; hi_in = 4'd9; n_in = 4'd3;
        repeat (2) @(posedge clk);
        #3;
        n_tests++; if (cnt_load !== 1'b0) begin n_fail++; $display("FAIL reset_cnt_load: got %b want 0", cnt_load); end
        n_tests++; if (cnt_load_val !== 4'd0) begin n_fail++; $display("FAIL reset_cnt_load_val: got %0d want 0", cnt_load_val); end
        n_tests++; if (cnt_en !== 1'b0) begin n_fail++; $display("FAIL reset_cnt_en: got %b want 0", cnt_en); end
        n_tests++; if (cnt_up !== 1'b0) begin n_fail++; $display("FAIL reset_cnt_up: got %b want 0", cnt_up); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        n_tests++; if (sweeps_done !== 4'd0) begin n_fail++; $display("FAIL reset_sweeps_done: got %0d want 0", sweeps_done); end
        reset = 1'b0; start = 1'b0;
        next_cyc(); #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %b want 0", busy); end
        $display("[TB] reset: outputs idle during and after reset");
    endtask

    task automatic test_basic_run;
        next_cyc();
        lo_in = 4'd3; hi_in = 4'd6; n_in = 4'd2; start = 1'b1; #1;
        n_tests++; if (cnt_load !== 1'b1 || cnt_load_val !== 4'd3) begin n_fail++; $display("FAIL basic_load: load=%b val=%0d want load=1 val=3", cnt_load, cnt_load_val); end
        for (int c = 1; c <= 15; c++) begin
            next_cyc(); start = 1'b0; #1;
            if (c <= 13) begin
                n_tests++; if (cnt_q !== 4'(exp_q[c])) begin n_fail++; $display("FAIL basic_q c%0d: got %0d want %0d", c, cnt_q, exp_q[c]); end
            end
            n_tests++; if (done !== (c == 14)) begin n_fail++; $display("FAIL basic_done c%0d: got %b want %b", c, done, (c == 14)); end
            n_tests++; if (busy !== (c <= 14)) begin n_fail++; $display("FAIL basic_busy c%0d: got %b want %b", c, busy, (c <= 14)); end
        end
        n_tests++; if (sweeps_done !== 4'd2) begin n_fail++; $display("FAIL basic_sweeps: got %0d want 2", sweeps_done); end
        $display("[TB] basic run lo=3 hi=6 n=2: done expected at c14");
    endtask

    task automatic test_invalid_start;
        logic [W-1:0]  v_lo [0:2];
        logic [W-1:0]  v_hi [0:2];
        logic [NW-1:0] v_n  [0:2];
        logic [W-1:0]  q0;
        v_lo = '{4'd6, 4'd2, 4'd9};
        v_hi = '{4'd6, 4'd5, 4'd4};
        v_n  = '{4'd1, 4'd0, 4'd3};
        for (int i = 0; i < 3; i++) begin
            next_cyc();
            q0 = cnt_q;
            lo_in = v_lo[i]; hi_in = v_hi[i]; n_in = v_n[i]; start = 1'b1; #1;
            n_tests++; if (cnt_load !== 1'b0) begin n_fail++; $display("FAIL invalid%0d_load: got %b want 0", i, cnt_load); end
            next_cyc(); start = 1'b0; #1;
            n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL invalid%0d_err: got %b want 1", i, err); end
            n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL invalid%0d_busy: got %b want 0", i, busy); end
            next_cyc(); #1;
            n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL invalid%0d_err_clear: got %b want 0", i, err); end
            n_tests++; if (cnt_q !== q0) begin n_fail++; $display("FAIL invalid%0d_q: got %0d want %0d", i, cnt_q, q0); end
            $display("[TB] invalid start lo=%0d hi=%0d n=%0d rejected", v_lo[i], v_hi[i], v_n[i]);
        end
    endtask

    task automatic test_full_range;
        int e;
        next_cyc();
        lo_in = 4'd0; hi_in = 4'd15; n_in = 4'd1; start = 1'b1; #1;
        n_tests++; if (cnt_load !== 1'b1 || cnt_load_val !== 4'd0) begin n_fail++; $display("FAIL full_load: load=%b val=%0d want load=1 val=0", cnt_load, cnt_load_val); end
        for (int c = 1; c <= 33; c++) begin
            next_cyc(); start = 1'b0; #1;
            e = (c <= 16) ? c - 1 : ((c <= 31) ? 31 - c : 0);
            if (c <= 32) begin
                n_tests++; if (cnt_q !== 4'(e)) begin n_fail++; $display("FAIL full_q c%0d: got %0d want %0d", c, cnt_q, e); end
            end
            n_tests++; if (done !== (c == 32)) begin n_fail++; $display("FAIL full_done c%0d: got %b want %b", c, done, (c == 32)); end
        end
        $display("[TB] full range lo=0 hi=15 n=1: done expected at c32");
    endtask

    task automatic test_pause;
        int e;
        next_cyc();
        lo_in = 4'd3; hi_in = 4'd6; n_in = 4'd2; start = 1'b1; #1;
        for (int c = 1; c <= 18; c++) begin
            next_cyc(); start = 1'b0; pause = (c >= 4 && c <= 6); #1;
            if (c <= 4) e = exp_q[c];
            else if (c <= 7) e = 6;
            else if (c <= 16) e = exp_q[c - 3];
            else e = 3;
            if (c <= 17) begin
                n_tests++; if (cnt_q !== 4'(e)) begin n_fail++; $display("FAIL pause_q c%0d: got %0d want %0d", c, cnt_q, e); end
            end
            if (c >= 4 && c <= 6) begin
                n_tests++; if (cnt_en !== 1'b0) begin n_fail++; $display("FAIL pause_en c%0d: got %b want 0", c, cnt_en); end
            end
            n_tests++; if (done !== (c == 17)) begin n_fail++; $display("FAIL pause_done c%0d: got %b want %b", c, done, (c == 17)); end
        end
        pause = 1'b0;
        n_tests++; if (sweeps_done !== 4'd2) begin n_fail++; $display("FAIL pause_sweeps: got %0d want 2", sweeps_done); end
        $display("[TB] pause 3 cycles at q=6: done expected at c17");
    endtask

    task automatic test_abort;
        next_cyc();
        lo_in = 4'd3; hi_in = 4'd6; n_in = 4'd2; start = 1'b1; #1;
        for (int c = 1; c <= 10; c++) begin
            next_cyc(); start = (c == 7); abort = (c == 5 || c == 9); #1;
            if (c == 5) begin
                n_tests++; if (cnt_en !== 1'b0) begin n_fail++; $display("FAIL abort_en: got %b want 0", cnt_en); end
            end
            if (c == 6) begin
                n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
                n_tests++; if (cnt_q !== 4'd5) begin n_fail++; $display("FAIL abort_q_hold: got %0d want 5", cnt_q); end
                n_tests++; if (sweeps_done !== 4'd0) begin n_fail++; $display("FAIL abort_sweeps: got %0d want 0", sweeps_done); end
            end
            if (c == 6 || c == 7 || c == 10) begin
                n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done c%0d: got %b want 0", c, done); end
            end
            if (c == 7) begin
                n_tests++; if (cnt_load !== 1'b1) begin n_fail++; $display("FAIL abort_restart_load: got %b want 1", cnt_load); end
            end
            if (c == 8) begin
                n_tests++; if (busy !== 1'b1 || cnt_q !== 4'd3) begin n_fail++; $display("FAIL abort_restart: busy=%b q=%0d want busy=1 q=3", busy, cnt_q); end
            end
            if (c == 10) begin
                n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort2_busy: got %b want 0", busy); end
            end
        end
        abort = 1'b0; start = 1'b0;
        $display("[TB] abort at c5, restart at c7, abort again at c9");
    endtask

    task automatic test_busy_start_and_reset;
        next_cyc();
        lo_in = 4'd3; hi_in = 4'd6; n_in = 4'd2; start = 1'b1; #1;
        for (int c = 1; c <= 5; c++) begin
            next_cyc();
            start = (c == 2);
            if (c == 2) begin lo_in = 4'd9; hi_in = 4'd12; n_in = 4'd1; end
            #1;
            if (c == 2) begin
                n_tests++; if (cnt_load !== 1'b0) begin n_fail++; $display("FAIL busy_start_load: got %b want 0", cnt_load); end
            end
            if (c == 3) begin
                n_tests++; if (cnt_q !== 4'd5) begin n_fail++; $display("FAIL busy_start_q: got %0d want 5", cnt_q); end
            end
            if (c == 5) begin
                n_tests++; if (cnt_q !== 4'd5 || busy !== 1'b1) begin n_fail++; $display("FAIL middown_state: q=%0d busy=%b want q=5 busy=1", cnt_q, busy); end
            end
        end
        // Asynchronous reset in the middle of a DOWN cycle, away from any edge.
        reset = 1'b1; #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy: got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL async_reset_done: got %b want 0", done); end
        n_tests++; if (cnt_en !== 1'b0) begin n_fail++; $display("FAIL async_reset_en: got %b want 0", cnt_en); end
        n_tests++; if (cnt_load !== 1'b0) begin n_fail++; $display("FAIL async_reset_load: got %b want 0", cnt_load); end
        n_tests++; if (sweeps_done !== 4'd0) begin n_fail++; $display("FAIL async_reset_sweeps: got %0d want 0", sweeps_done); end
        #2; reset = 1'b0;
        next_cyc(); #1;
        n_tests++; if (busy !== 1'b0 || cnt_q !== 4'd5) begin n_fail++; $display("FAIL after_reset: busy=%b q=%0d want busy=0 q=5", busy, cnt_q); end
        $display("[TB] start while busy ignored; async reset mid-DOWN");
    endtask

    task automatic test_back_to_back;
        int e;
        int eq [0:11];
        eq = '{0, 7, 8, 7, 7, 7, 14, 15, 14, 15, 14, 14};
        next_cyc();
        lo_in = 4'd7; hi_in = 4'd8; n_in = 4'd1; start = 1'b1; #1;
        for (int c = 1; c <= 12; c++) begin
            next_cyc();
            start = (c == 5);
            if (c == 5) begin lo_in = 4'd14; hi_in = 4'd15; n_in = 4'd2; end
            #1;
            if (c <= 11) begin
                e = eq[c];
                n_tests++; if (cnt_q !== 4'(e)) begin n_fail++; $display("FAIL b2b_q c%0d: got %0d want %0d", c, cnt_q, e); end
            end
            n_tests++; if (done !== (c == 4 || c == 11)) begin n_fail++; $display("FAIL b2b_done c%0d: got %b want %b", c, done, (c == 4 || c == 11)); end
            n_tests++; if (busy !== (c <= 4 || (c >= 6 && c <= 11))) begin n_fail++; $display("FAIL b2b_busy c%0d: got %b want %b", c, busy, (c <= 4 || (c >= 6 && c <= 11))); end
            if (c == 4) begin
                n_tests++; if (sweeps_done !== 4'd1) begin n_fail++; $display("FAIL b2b_sweeps1: got %0d want 1", sweeps_done); end
            end
            if (c == 5) begin
                n_tests++; if (cnt_load !== 1'b1 || cnt_load_val !== 4'd14) begin n_fail++; $display("FAIL b2b_reload: load=%b val=%0d want load=1 val=14", cnt_load, cnt_load_val); end
            end
            if (c == 12) begin
                n_tests++; if (sweeps_done !== 4'd2) begin n_fail++; $display("FAIL b2b_sweeps2: got %0d want 2", sweeps_done); end
            end
        end
        start = 1'b0;
        $display("[TB] back-to-back minimum runs 7..8 x1 then 14..15 x2");
    endtask

    initial begin
        exp_q = '{0, 3, 4, 5, 6, 5, 4, 3, 4, 5, 6, 5, 4, 3};
        test_reset();
        test_basic_run();
        test_invalid_start();
        test_full_range();
        test_pause();
        test_abort();
        test_busy_start_and_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
